// File: rtl/cog_pkg.sv
// Shared types and constants for the CoG point transmitter.
package cog_pkg;

    localparam int FRAC_BITS  = 4;
    localparam int Q_WIDTH    = 11;
    localparam int DIVIDEND_W = 34;
    localparam int DIVISOR_W  = 23;

    localparam logic [15:0] EOL_MARKER = 16'hFFFF;
    localparam logic [15:0] EOF_MARKER = 16'hFFFE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POP      = 3'd1,
        DIV      = 3'd2,
        SEND_PT  = 3'd3,
        SEND_EOL = 3'd4,
        SEND_EOF = 3'd5
    } tx_state_t;

    // One captured strobe cycle; flags sit in the low bits.
    typedef struct packed {
        logic [29:0] sum_ixc;
        logic [22:0] sum_i;
        logic [10:0] start_point;
        logic        pt;
        logic        eol;
        logic        eof;
        logic        sof;
    } cog_event_t;

endpackage

// File: rtl/cog_serial_divider.sv
// Restoring divider, one quotient bit per cycle, 11 cycles per result.
// Divide-by-zero yields 0; quotients that do not fit 11 bits saturate.
module cog_serial_divider
    import cog_pkg::*;
(
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [Q_WIDTH-1:0]    quotient_o
);

    logic                  busy_q, busy_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dsh_q, dsh_d;
    logic [Q_WIDTH-2:0]    q_q, q_d;
    logic                  zero_q, zero_d;
    logic                  sat_q, sat_d;
    logic                  ge;

    // The current trial subtraction; its result is also the last quotient bit.
    assign ge = (rem_q >= dsh_q);

    // Load on start, then shift the divisor right one place per cycle.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dsh_d  = dsh_q;
        q_d    = q_q;
        zero_d = zero_q;
        sat_d  = sat_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = 4'd10;
            rem_d  = dividend_i;
            dsh_d  = {1'b0, divisor_i, 10'b0};
            q_d    = '0;
            zero_d = (divisor_i == '0);
            sat_d  = (dividend_i >= {divisor_i, 11'b0});
        end else if (busy_q) begin
            rem_d = ge ? (rem_q - dsh_q) : rem_q;
            dsh_d = dsh_q >> 1;
            q_d   = {q_q[Q_WIDTH-3:0], ge};
            if (cnt_q == 4'd0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Divider state registers; reset abandons any partial quotient.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dsh_q  <= '0;
            q_q    <= '0;
            zero_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            dsh_q  <= dsh_d;
            q_q    <= q_d;
            zero_q <= zero_d;
            sat_q  <= sat_d;
        end
    end

    assign done_o     = busy_q && (cnt_q == 4'd0);
    assign quotient_o = zero_q ? '0 :
                        sat_q  ? {Q_WIDTH{1'b1}} :
                                 {q_q, ge};

endmodule

// File: rtl/cog_point_transmitter.sv
// Buffers figure events, divides out the sub-pixel centre and streams
// coordinates plus line/frame markers over a 16-bit AXI4-Stream.
//
// state    | meaning
// IDLE     | waiting for a buffered event
// POP      | read FIFO head, start divider if it carries a point
// DIV      | serial division in progress
// SEND_PT  | coordinate beat presented
// SEND_EOL | end-of-line marker beat presented
// SEND_EOF | end-of-frame marker beat presented
module cog_point_transmitter
    import cog_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 1280
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_aresetn,
    input  logic [29:0] i_sum_of_I_mult_coord,
    input  logic [22:0] i_sum_of_I,
    input  logic [10:0] i_start_point,
    input  logic        i_point_is_valid,
    input  logic        i_end_of_line,
    input  logic        i_end_of_frame,
    input  logic        i_new_frame,
    output logic [15:0] o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic        o_tlast,
    output logic        o_tuser,
    output logic        o_overflow,
    output logic        o_busy
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] COORD_MAX = 16'((WIDTH << FRAC_BITS) - 1);

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
    cog_event_t  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        overflow_q, overflow_d;
    cog_event_t  wr_ev, head;
    logic        any_strobe, fifo_empty, fifo_full, do_write, do_pop;

    tx_state_t    state_q, state_d;
    logic         eol_q, eol_d, eof_q, eof_d;
    logic         tuser_q, tuser_d;
    logic [10:0]  start_q, start_d;
    logic [14:0]  coord_q, coord_d;
    logic         div_start, div_done;
    logic [Q_WIDTH-1:0] quotient;
    logic [15:0]  coord_sum;

    assign any_strobe = i_point_is_valid | i_end_of_line | i_end_of_frame | i_new_frame;
    assign wr_ev      = '{sum_ixc: i_sum_of_I_mult_coord, sum_i: i_sum_of_I,
                          start_point: i_start_point, pt: i_point_is_valid,
                          eol: i_end_of_line, eof: i_end_of_frame, sof: i_new_frame};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_write   = any_strobe && !fifo_full;
    assign do_pop     = (state_q == POP);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // A new frame always clears the sticky drop flag, even if it is itself dropped.
    assign overflow_d = i_new_frame ? 1'b0 :
                        (any_strobe && fifo_full) ? 1'b1 : overflow_q;

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge i_sys_clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_ev;
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)   rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            overflow_q <= overflow_d;
        end
    end

    cog_serial_divider u_div (
        .i_sys_clk     (i_sys_clk),
        .i_sys_aresetn (i_sys_aresetn),
        .start_i       (div_start),
        .dividend_i    ({head.sum_ixc, {FRAC_BITS{1'b0}}}),
        .divisor_i     (head.sum_i),
        .done_o        (div_done),
        .quotient_o    (quotient)
    );

    // 16-bit sum so a large start point plus quotient cannot wrap before clamping.
    assign coord_sum = {1'b0, start_q, {FRAC_BITS{1'b0}}} + {5'b0, quotient};

    // Next-state and datapath control; beats advance only on a handshake.
    always_comb begin
        state_d   = state_q;
        eol_d     = eol_q;
        eof_d     = eof_q;
        tuser_d   = tuser_q;
        start_d   = start_q;
        coord_d   = coord_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = POP;
            end
            POP: begin
                eol_d     = head.eol;
                eof_d     = head.eof;
                start_d   = head.start_point;
                div_start = head.pt;
                if (head.sof) tuser_d = 1'b1;
                if (head.pt)       state_d = DIV;
                else if (head.eol) state_d = SEND_EOL;
                else if (head.eof) state_d = SEND_EOF;
                else               state_d = IDLE;
            end
            DIV: begin
                if (div_done) begin
                    coord_d = (coord_sum > COORD_MAX) ? COORD_MAX[14:0] : coord_sum[14:0];
                    state_d = SEND_PT;
                end
            end
            SEND_PT: begin
                if (i_tready) begin
                    tuser_d = 1'b0;
                    if (eol_q)      state_d = SEND_EOL;
                    else if (eof_q) state_d = SEND_EOF;
                    else            state_d = IDLE;
                end
            end
            SEND_EOL: begin
                if (i_tready) begin
                    tuser_d = 1'b0;
                    state_d = eof_q ? SEND_EOF : IDLE;
                end
            end
            SEND_EOF: begin
                if (i_tready) begin
                    tuser_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and beat registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q <= IDLE;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            tuser_q <= 1'b0;
            start_q <= '0;
            coord_q <= '0;
        end else begin
            state_q <= state_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            tuser_q <= tuser_d;
            start_q <= start_d;
            coord_q <= coord_d;
        end
    end

    // Beat payload is a pure function of state so it stays stable while stalled.
    always_comb begin
        o_tdata = 16'h0000;
        case (state_q)
            SEND_PT:  o_tdata = {1'b0, coord_q};
            SEND_EOL: o_tdata = EOL_MARKER;
            SEND_EOF: o_tdata = EOF_MARKER;
            default:  o_tdata = 16'h0000;
        endcase
    end

    assign o_tvalid   = (state_q == SEND_PT) || (state_q == SEND_EOL) || (state_q == SEND_EOF);
    assign o_tlast    = (state_q == SEND_EOL) || (state_q == SEND_EOF);
    assign o_tuser    = o_tvalid && tuser_q;
    assign o_overflow = overflow_q;
    assign o_busy     = !fifo_empty || (state_q != IDLE);

endmodule
